// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS memory-map constants
package mips_pkg;
  localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
  localparam int          DEPTH_LOG2 = 14;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
endpackage

// File: rtl/imem_addr_xlate.sv
// rtl/imem_addr_xlate.sv - byte address to imem word index plus legality
module imem_addr_xlate #(
  parameter logic [31:0] TEXT_BASE  = mips_pkg::TEXT_BASE,
  parameter int          DEPTH_LOG2 = mips_pkg::DEPTH_LOG2
) (
  input  logic [31:0]           addr,
  output logic [DEPTH_LOG2-1:0] idx,
  output logic                  legal
);
  localparam logic [32:0] LIMIT = 33'd4 << DEPTH_LOG2;

  logic [32:0] off;

  // A 33-bit offset sets bit 32 on underflow, so addresses below the base fail the limit test
  assign off   = {1'b0, addr} - {1'b0, TEXT_BASE};
  assign idx   = off[DEPTH_LOG2+1:2];
  assign legal = (addr[1:0] == 2'b00) && (off < LIMIT);
endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port imem arbiter between CPU fetch and loader
module imem_arbiter #(
  parameter logic [31:0] TEXT_BASE    = mips_pkg::TEXT_BASE,
  parameter int          DEPTH_LOG2   = mips_pkg::DEPTH_LOG2,
  parameter int          MAX_LD_BURST = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_valid,
  output logic [31:0]           fetch_rdata,
  output logic                  fetch_err,
  output logic                  cpu_stall,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic                  ld_lock,
  input  logic [31:0]           ld_addr,
  input  logic [31:0]           ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_valid,
  output logic [31:0]           ld_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  localparam int              BW        = $clog2(MAX_LD_BURST + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_LD_BURST);

  logic [BW-1:0]         burst_cnt;
  logic                  burst_full;
  logic [DEPTH_LOG2-1:0] f_idx, l_idx;
  logic                  f_legal, l_legal;
  logic                  ld_ok;

  imem_addr_xlate #(.TEXT_BASE(TEXT_BASE), .DEPTH_LOG2(DEPTH_LOG2)) u_fetch_xlate (
    .addr  (fetch_addr),
    .idx   (f_idx),
    .legal (f_legal)
  );

  imem_addr_xlate #(.TEXT_BASE(TEXT_BASE), .DEPTH_LOG2(DEPTH_LOG2)) u_ld_xlate (
    .addr  (ld_addr),
    .idx   (l_idx),
    .legal (l_legal)
  );

  // Grants are qualified by reset_n so nothing reaches memory while reset is held
  assign burst_full = (burst_cnt == BURST_MAX);
  assign fetch_gnt  = reset_n & fetch_req & ~ld_lock & (~ld_req | burst_full);
  assign ld_gnt     = reset_n & ld_req & ~fetch_gnt;
  assign cpu_stall  = reset_n & fetch_req & ~fetch_gnt;

  assign mem_en    = (fetch_gnt & f_legal) | (ld_gnt & l_legal);
  assign mem_we    = ld_gnt & l_legal & ld_we;
  assign mem_addr  = ld_gnt ? l_idx : f_idx;
  assign mem_wdata = ld_gnt ? ld_wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt   <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      ld_valid    <= 1'b0;
      ld_ok       <= 1'b0;
    end else begin
      fetch_valid <= fetch_gnt;
      fetch_err   <= fetch_gnt & ~f_legal;
      ld_valid    <= ld_gnt & ~ld_we;
      ld_ok       <= ld_gnt & ~ld_we & l_legal;
      if (fetch_gnt || !fetch_req)
        burst_cnt <= '0;
      else if (ld_gnt && !burst_full)
        burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Read data comes straight from the 1-cycle memory; illegal reads return zero
  assign fetch_rdata = (fetch_valid && !fetch_err) ? mem_rdata : mips_pkg::NOP_WORD;
  assign ld_rdata    = ld_ok ? mem_rdata : '0;
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The module SHALL have parameter TEXT_BASE, default 32'h00400000, the byte address of instruction word 0.
REQ-002 The module SHALL have parameter DEPTH_LOG2, default 14, the log2 of the instruction-memory depth in words.
REQ-003 The module SHALL have parameter MAX_LD_BURST, default 8, the maximum number of consecutive loader grants while fetch is waiting.
REQ-004 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- fetch_req  in  1  fetch read request
- fetch_addr  in  32  fetch byte address (PC)
- fetch_gnt  out  1  fetch access issued this cycle
- fetch_valid  out  1  fetch_rdata/fetch_err valid
- fetch_rdata  out  32  fetched word
- fetch_err  out  1  fetch address misaligned or out of range
- cpu_stall  out  1  hold PC/IR this cycle
- ld_req  in  1  loader request
- ld_we  in  1  loader write (1) or read (0)
- ld_lock  in  1  loader owns memory exclusively
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  loader access issued this cycle
- ld_valid  out  1  loader read data valid
- ld_rdata  out  32  loader read data
- mem_en  out  1  memory port enable
- mem_we  out  1  memory write enable
- mem_addr  out  DEPTH_LOG2  word index
- mem_wdata  out  32  write data
- mem_rdata  in  32  sync read data, 1-cycle latency

Function
REQ-006 Word index SHALL be (addr - TEXT_BASE) >> 2, truncated to DEPTH_LOG2 bits; an address is legal iff addr[1:0]==0 and addr-TEXT_BASE < 4*2^DEPTH_LOG2, evaluated without wrap-around.
REQ-007 At most one of fetch_gnt/ld_gnt SHALL be high per cycle; grants SHALL be combinational from the requests and the burst-count state.
REQ-008 Priority SHALL be as follows: ld_lock=1 gives the loader exclusive access and fetch is never granted; otherwise the loader wins unless burst_cnt==MAX_LD_BURST and fetch_req=1, in which case fetch wins.
REQ-009 burst_cnt SHALL increment on each ld_gnt while fetch_req=1, saturating at MAX_LD_BURST, and SHALL clear on fetch_gnt or when fetch_req=0.
REQ-010 A granted legal access SHALL drive mem_en=1, with mem_we=ld_we for the loader and mem_we=0 for fetch, and mem_addr and mem_wdata from the winner.
REQ-011 A granted illegal access SHALL drive mem_en=0.
REQ-012 For fetch, an illegal granted access SHALL produce fetch_valid=1, fetch_err=1 and fetch_rdata=32'h0 on the next cycle.
REQ-013 For the loader, an illegal write SHALL be dropped silently, and an illegal read SHALL return ld_rdata=0.
REQ-014 Read latency SHALL be exactly 1 cycle: fetch_valid/ld_valid SHALL be registered pulses one cycle after the grant, and fetch_rdata/ld_rdata SHALL equal mem_rdata for legal reads.
REQ-015 Loader writes SHALL produce no ld_valid.
REQ-016 cpu_stall SHALL equal fetch_req & ~fetch_gnt.
REQ-017 Back-to-back grants SHALL sustain one access per cycle with no bubble.
REQ-018 When fetch_req and ld_req are both asserted in the same cycle with burst_cnt<MAX_LD_BURST, the loader SHALL win and cpu_stall SHALL be 1.
REQ-019 Deasserting ld_lock SHALL allow fetch to be granted in the same cycle.

Reset
REQ-020 While reset_n=0, all of the following SHALL be 0: fetch_gnt, ld_gnt, mem_en, mem_we, fetch_valid, ld_valid, fetch_err, cpu_stall, fetch_rdata, ld_rdata and burst_cnt.
REQ-021 A read in flight when reset asserts SHALL be discarded, producing no valid pulse after reset_n rises.
REQ-022 The first grant after reset SHALL be possible on the first rising edge with reset_n=1.

Structure
REQ-023 TEXT_BASE, the default DEPTH_LOG2 and the NOP word 32'h0 SHALL live in the shared package mips_pkg.
REQ-024 The legality check and index computation SHALL be one sub-module, imem_addr_xlate, instantiated twice (fetch, loader).

Verification
REQ-025 Fetch only, fetch_addr=32'h00400008, memory word 2=32'h2402000A SHALL give fetch_gnt=1, mem_addr=2 and, the next cycle, fetch_valid=1 with fetch_rdata=32'h2402000A.
REQ-026 Fetch with fetch_addr=32'h00400002 and then 32'h00410000 SHALL give mem_en=0 and fetch_valid=1, fetch_err=1, fetch_rdata=0 for both.
REQ-027 ld_req=1 continuously with fetch_req=1 and MAX_LD_BURST=8 SHALL give 8 ld_gnt, then 1 fetch_gnt, repeating, with cpu_stall high for exactly the 8 loader cycles.
REQ-028 ld_lock=1 for 20 cycles with fetch_req=1 SHALL give fetch_gnt=0 and cpu_stall=1 throughout; the cycle ld_lock falls, fetch_gnt=1.
REQ-029 A loader write of 32'hDEADBEEF to 32'h00400010 followed by a fetch from the same address SHALL return fetch_rdata=32'hDEADBEEF.
REQ-030 reset_n low in the cycle after a fetch grant SHALL give fetch_valid=0 during and after reset, and burst_cnt=0.
